// File: rtl/unary_run_counter.sv
// unary_run_counter
// Streams W_IN-bit words MSB-first and counts the leading run of ones (or
// zeros) across word boundaries. When the run ends it emits one registered
// result: the total length, the terminator position in the final word, and
// the saturation and no-terminator flags.
module unary_run_counter #(
    parameter int W_IN  = 8,
    parameter int W_CNT = 16,
    parameter int W_IDX = $clog2(W_IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  in_data,
    input  logic             in_mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_CNT-1:0] out_count,
    output logic [W_IDX-1:0] out_idx,
    output logic             out_sat,
    output logic             out_noterm
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [W_CNT-1:0] CNT_MAX = {W_CNT{1'b1}};
    localparam int W_LEAD = W_IDX + 1;

    state_t             state_reg, state_next;
    logic [W_CNT-1:0]   acc_reg, acc_next;
    logic               sat_reg, sat_next;
    logic               mode_reg, mode_next;
    logic               out_valid_reg, out_valid_next;
    logic [W_CNT-1:0]   out_count_reg, out_count_next;
    logic [W_IDX-1:0]   out_idx_reg, out_idx_next;
    logic               out_sat_reg, out_sat_next;
    logic               out_noterm_reg, out_noterm_next;

    logic               mode_eff;
    logic [W_IN-1:0]    norm;
    logic               all_match;
    logic [W_LEAD-1:0]  tree_lead;
    logic [W_LEAD-1:0]  lead;
    logic [W_CNT:0]     sum_wide;
    logic [W_CNT-1:0]   sum_clamped;
    logic               sat_run;
    logic               xfer;

    // The mode only comes from the port on the first word of a run.
    assign mode_eff  = (state_reg == IDLE) ? in_mode : mode_reg;
    assign norm      = in_data ^ {W_IN{mode_eff}};
    assign all_match = &norm;

    // Balanced leading-ones tree. Node 0 of each level is the most significant
    // slice; a parent takes its left count unless the left half is all ones,
    // in which case the right count is added to the left width.
    for (genvar gl = 0; gl <= W_IDX; gl++) begin : g_lvl
        localparam int N = W_IN >> gl;
        logic [N-1:0]             all_m;
        logic [N-1:0][W_LEAD-1:0] cnt;
        for (genvar gi = 0; gi < N; gi++) begin : g_node
            if (gl == 0) begin : g_leaf
                assign all_m[gi] = norm[W_IN-1-gi];
                assign cnt[gi]   = {{W_IDX{1'b0}}, norm[W_IN-1-gi]};
            end else begin : g_join
                localparam logic [W_LEAD-1:0] HALF = W_LEAD'(1 << (gl - 1));
                assign all_m[gi] = g_lvl[gl-1].all_m[2*gi] & g_lvl[gl-1].all_m[2*gi+1];
                assign cnt[gi]   = g_lvl[gl-1].all_m[2*gi]
                                 ? HALF + g_lvl[gl-1].cnt[2*gi+1]
                                 : g_lvl[gl-1].cnt[2*gi];
            end
        end
    end

    assign tree_lead = g_lvl[W_IDX].cnt[0];
    // All-ones override pins the count to the full word width.
    assign lead      = all_match ? W_LEAD'(W_IN) : tree_lead;

    // Saturating accumulation; the saturation flag is sticky for the run.
    assign sum_wide    = {1'b0, acc_reg} + (W_CNT + 1)'(lead);
    assign sum_clamped = sum_wide[W_CNT] ? CNT_MAX : sum_wide[W_CNT-1:0];
    assign sat_run     = sat_reg | sum_wide[W_CNT];

    assign in_ready   = !out_valid_reg || out_ready;
    assign xfer       = in_valid && in_ready;

    assign out_valid  = out_valid_reg;
    assign out_count  = out_count_reg;
    assign out_idx    = out_idx_reg;
    assign out_sat    = out_sat_reg;
    assign out_noterm = out_noterm_reg;

    // Next-state and result-load logic for the run FSM.
    always_comb begin
        state_next      = state_reg;
        acc_next        = acc_reg;
        sat_next        = sat_reg;
        mode_next       = mode_reg;
        out_valid_next  = out_valid_reg && !out_ready;
        out_count_next  = out_count_reg;
        out_idx_next    = out_idx_reg;
        out_sat_next    = out_sat_reg;
        out_noterm_next = out_noterm_reg;

        if (xfer) begin
            if (all_match && !in_last) begin
                acc_next   = sum_clamped;
                sat_next   = sat_run;
                mode_next  = mode_eff;
                state_next = RUN;
            end else begin
                out_valid_next  = 1'b1;
                out_count_next  = sum_clamped;
                out_idx_next    = all_match ? '0 : lead[W_IDX-1:0];
                out_sat_next    = sat_run;
                out_noterm_next = all_match;
                acc_next        = '0;
                sat_next        = 1'b0;
                state_next      = IDLE;
            end
        end
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            acc_reg        <= '0;
            sat_reg        <= 1'b0;
            mode_reg       <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_count_reg  <= '0;
            out_idx_reg    <= '0;
            out_sat_reg    <= 1'b0;
            out_noterm_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            acc_reg        <= acc_next;
            sat_reg        <= sat_next;
            mode_reg       <= mode_next;
            out_valid_reg  <= out_valid_next;
            out_count_reg  <= out_count_next;
            out_idx_reg    <= out_idx_next;
            out_sat_reg    <= out_sat_next;
            out_noterm_reg <= out_noterm_next;
        end
    end

endmodule
